// File: rtl/rv_pkg.sv
// Shared constants and helpers for the rv_data_fifo stage and its storage.
package rv_pkg;

  localparam logic RV_RESET_DATA    = '0;
  localparam int   RV_DEFAULT_DEPTH = 8;

  // Pointer and level width: one extra bit so full and empty can be told apart.
  function automatic int rv_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [rv_ptr_w(RV_DEFAULT_DEPTH)-1:0] rv_level_t;

endpackage

// File: rtl/rv_fifo_mem.sv
// Storage array for rv_data_fifo: synchronous write, asynchronous read, async clear to zero.
module rv_fifo_mem
  import rv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {WIDTH{RV_RESET_DATA}};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv_data_fifo.sv
// Ready/valid FIFO stage absorbing consumer back-pressure.
// Optional statistics (hwm, full_cyc) are built when RV_DATA_FIFO_STATS_EN is defined.
module rv_data_fifo
  import rv_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              i_data,
  input  logic                          i_data_valid,
  output logic                          i_data_ready,
  output logic [WIDTH-1:0]              o_data,
  output logic                          o_data_valid,
  input  logic                          o_data_ready,
  output logic [rv_ptr_w(DEPTH)-1:0]    level,
`ifdef RV_DATA_FIFO_STATS_EN
  output logic [rv_ptr_w(DEPTH)-1:0]    hwm,
  output logic [31:0]                   full_cyc,
`endif
  output logic                          almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = rv_ptr_w(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);

  typedef logic [LW-1:0] level_t;

  level_t wr_ptr, rd_ptr, level_q, level_nxt;
  logic   push, pop, full;

  // Ready depends only on registered pointers, so a pop never frees a slot in the same cycle.
  assign full         = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign i_data_ready = !reset && !full;
  assign o_data_valid = (level_q != '0);
  assign push         = i_data_valid && i_data_ready;
  assign pop          = o_data_valid && o_data_ready;

  always_comb begin
    level_nxt = level_q;
    case ({push, pop})
      2'b10:   level_nxt = level_q + LW'(1);
      2'b01:   level_nxt = level_q - LW'(1);
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
      level_q <= level_nxt;
    end
  end

  assign level       = level_q;
  assign almost_full = (level_q >= AFULL_L);

  rv_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr[PW-1:0]),
    .wdata (i_data),
    .raddr (rd_ptr[PW-1:0]),
    .rdata (o_data)
  );

`ifdef RV_DATA_FIFO_STATS_EN
  level_t      hwm_q;
  logic [31:0] full_cyc_q;

  // Tracking the next level keeps hwm equal to the peak level already visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hwm_q      <= '0;
      full_cyc_q <= '0;
    end else begin
      if (level_nxt > hwm_q) hwm_q <= level_nxt;
      if (i_data_valid && (level_q == DEPTH_L) && (full_cyc_q != 32'hFFFF_FFFF))
        full_cyc_q <= full_cyc_q + 32'd1;
    end
  end

  assign hwm      = hwm_q;
  assign full_cyc = full_cyc_q;
`endif

endmodule
